// File: rtl/sha256_w_stream_gen.sv
// Streams the SHA-256 message schedule W0..W[NUM_WORDS-1] from a 16-word sliding window.
// Latency: first word one cycle after start. Backpressure: w_ready=0 freezes word, index and window.
module sha256_w_stream_gen #(
    parameter int NUM_WORDS = 64
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         start,
    input  logic [511:0] block_in,
    output logic         busy,
    output logic         w_valid,
    input  logic         w_ready,
    output logic [31:0]  w_out,
    output logic [5:0]   w_idx,
    output logic         done
);

    localparam logic [5:0] LAST_IDX = 6'(NUM_WORDS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] win [16];
    logic [5:0]  idx;
    logic        load;
    logic        xfer;
    logic        last;
    logic        done_q;
    logic [31:0] w_new;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    assign w_new = sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        xfer      = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                xfer = w_ready;
                last = (idx == LAST_IDX);
                if (xfer && last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The final transfer leaves window and index untouched so w_out/w_idx hold the last word in IDLE.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < 16; i++) begin
                win[i] <= '0;
            end
            idx    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= xfer && last;
            if (load) begin
                for (int i = 0; i < 16; i++) begin
                    win[i] <= block_in[511 - 32*i -: 32];
                end
                idx <= '0;
            end else if (xfer && !last) begin
                for (int i = 0; i < 15; i++) begin
                    win[i] <= win[i+1];
                end
                win[15] <= w_new;
                idx     <= idx + 6'd1;
            end
        end
    end

    assign busy    = (state == RUN);
    assign w_valid = (state == RUN);
    assign w_out   = win[0];
    assign w_idx   = idx;
    assign done    = done_q;

endmodule

// File: tb/tb_sha256_w_stream_gen.sv
// Bench for sha256_w_stream_gen: a cycle model at the falling edge predicts valid/busy/done and
// pops expected schedule words from a queue filled when a start is accepted.
module tb_sha256_w_stream_gen;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         start = 1'b0;
    logic [511:0] block_in = '0;
    logic         busy, w_valid, done;
    logic         w_ready = 1'b1;
    logic [31:0]  w_out;
    logic [5:0]   w_idx;

    logic         start17 = 1'b0;
    logic [511:0] blk17 = '0;
    logic         busy17, valid17, done17;
    logic [31:0]  out17;
    logic [5:0]   idx17;

    always #5 CLK = ~CLK;

    sha256_w_stream_gen dut (
        .CLK(CLK), .RST(RST), .start(start), .block_in(block_in),
        .busy(busy), .w_valid(w_valid), .w_ready(w_ready),
        .w_out(w_out), .w_idx(w_idx), .done(done)
    );

    sha256_w_stream_gen #(.NUM_WORDS(17)) dut17 (
        .CLK(CLK), .RST(RST), .start(start17), .block_in(blk17),
        .busy(busy17), .w_valid(valid17), .w_ready(1'b1),
        .w_out(out17), .w_idx(idx17), .done(done17)
    );

    typedef struct {
        logic [31:0] w;
        logic [5:0]  i;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_w [64];
    logic [31:0] dut_w [64];
    bit          model_run = 1'b0;
    bit          exp_done  = 1'b0;
    logic [31:0] last_w = '0;
    logic [5:0]  last_i = '0;
    int          n_total = 0;
    int          n_pass  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic void calc_sched(input logic [511:0] b);
        for (int t = 0; t < 16; t++) ref_w[t] = b[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++)
            ref_w[t] = (rr(ref_w[t-2], 17) ^ rr(ref_w[t-2], 19) ^ (ref_w[t-2] >> 10))
                     + ref_w[t-7]
                     + (rr(ref_w[t-15], 7) ^ rr(ref_w[t-15], 18) ^ (ref_w[t-15] >> 3))
                     + ref_w[t-16];
    endfunction

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom();
        return b;
    endfunction

    // Reference model of the stream; evaluated where inputs are stable before the next rising edge.
    always @(negedge CLK) begin
        if (RST) begin
            check("w_valid", 32'(w_valid), 32'(model_run));
            check("busy", 32'(busy), 32'(model_run));
            check("done", 32'(done), 32'(exp_done));
            exp_done = 1'b0;
            if (model_run) begin
                if (exp_q.size() == 0) begin
                    check("queue_underrun", 32'd1, 32'd0);
                    model_run = 1'b0;
                end else begin
                    check("w_out", w_out, exp_q[0].w);
                    check("w_idx", 32'(w_idx), 32'(exp_q[0].i));
                    if (w_ready) begin
                        dut_w[w_idx] = w_out;
                        last_w = exp_q[0].w;
                        last_i = exp_q[0].i;
                        void'(exp_q.pop_front());
                        if (last_i == 6'd63) begin
                            model_run = 1'b0;
                            exp_done  = 1'b1;
                        end
                    end
                end
            end else begin
                check("idle_w_out", w_out, last_w);
                check("idle_w_idx", 32'(w_idx), 32'(last_i));
                if (start) begin
                    calc_sched(block_in);
                    for (int t = 0; t < 64; t++) exp_q.push_back('{w: ref_w[t], i: 6'(t)});
                    model_run = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_block(input logic [511:0] b);
        start    = 1'b1;
        block_in = b;
        tick();
        start    = 1'b0;
        block_in = rand_block();
    endtask

    task automatic run_until_done(input bit rnd, output int cyc);
        cyc = 0;
        for (int n = 0; n < 2000; n++) begin
            if (rnd) w_ready = 1'($urandom_range(0, 1));
            tick();
            cyc++;
            if (done) begin
                w_ready = 1'b1;
                return;
            end
        end
        w_ready = 1'b1;
        check("done_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_idx(input int k);
        for (int n = 0; n < 500; n++) begin
            if (w_valid && w_idx == 6'(k)) return;
            tick();
        end
        check("idx_timeout", 32'(k), 32'hFFFF_FFFF);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] abc;
        int           cyc;
        abc = '0;
        abc[511:480] = 32'h6162_6380;
        abc[31:0]    = 32'h0000_0018;

        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(w_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_w_out", w_out, 32'd0);
        check("rst_w_idx", 32'(w_idx), 32'd0);

        // Start in the first edge after reset release, full-rate consumer.
        RST = 1'b1;
        start_block(abc);
        run_until_done(1'b0, cyc);
        check("abc_cycles", 32'(cyc), 32'd64);
        check("abc_w16", dut_w[16], 32'h6162_6380);
        check("abc_w17", dut_w[17], 32'h000F_0000);
        check("abc_w15", dut_w[15], 32'h0000_0018);
        tick();

        // Same block under random backpressure.
        start_block(abc);
        run_until_done(1'b1, cyc);
        check("abc_bp_w17", dut_w[17], 32'h000F_0000);
        tick();

        // Starts while running are ignored; start in the done cycle is accepted.
        start_block(rand_block());
        wait_idx(10);
        start    = 1'b1;
        block_in = rand_block();
        tick();
        start = 1'b0;
        wait_idx(63);
        start    = 1'b1;
        block_in = rand_block();
        tick();
        check("done_cycle_pulse", 32'(done), 32'd1);
        tick();
        start = 1'b0;
        check("restart_valid", 32'(w_valid), 32'd1);
        check("restart_idx", 32'(w_idx), 32'd0);
        run_until_done(1'b0, cyc);
        tick();

        // Asynchronous reset mid-stream.
        start_block(rand_block());
        wait_idx(37);
        #2 RST = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_valid", 32'(w_valid), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_w_out", w_out, 32'd0);
        check("arst_w_idx", 32'(w_idx), 32'd0);
        exp_q.delete();
        model_run = 1'b0;
        exp_done  = 1'b0;
        last_w    = '0;
        last_i    = '0;
        tick();
        tick();
        RST = 1'b1;
        tick();
        tick();
        tick();
        start_block(rand_block());
        run_until_done(1'b0, cyc);
        tick();

        // Short build: exactly 17 words then done.
        blk17   = rand_block();
        start17 = 1'b1;
        calc_sched(blk17);
        tick();
        start17 = 1'b0;
        blk17   = rand_block();
        for (int t = 0; t < 17; t++) begin
            @(negedge CLK);
            check("n17_valid", 32'(valid17), 32'd1);
            check("n17_w_out", out17, ref_w[t]);
            check("n17_w_idx", 32'(idx17), 32'(t));
        end
        @(negedge CLK);
        check("n17_done", 32'(done17), 32'd1);
        check("n17_valid_end", 32'(valid17), 32'd0);
        check("n17_busy_end", 32'(busy17), 32'd0);
        check("n17_hold", out17, ref_w[16]);
        @(negedge CLK);
        check("n17_done_once", 32'(done17), 32'd0);
        tick();

        // Random blocks back to back, each started in the previous block's done cycle.
        for (int b = 0; b < 1000; b++) begin
            start_block(rand_block());
            run_until_done(b < 40, cyc);
        end
        tick();
        tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
